// File: rtl/lru_repl_sequencer.sv
// ---------------------------------------------------------------------------
// lru_repl_sequencer
//
// Runs one cache access at a time through the shared single-port LRU state
// memory and the line-fill path. A hit reads the LRU row and marks the hit
// way most-recent. A miss reads the LRU row, latches the victim way,
// optionally writes it back (dirty), refills it, then marks it most-recent.
// The lru_* ports connect straight to LRU_Unit.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   req_valid_i/ready_o  request handshake; ready only while idle
//   req_index_i          set index of the access
//   req_hit_i/req_way_i  hit flag and hit way (way ignored on a miss)
//   victim_dirty_i       victim line dirty, sampled in DECIDE
//   lru_addr_o           LRU row address, held for the whole access
//   lru_way_o/lru_we_o   way to mark most-recent and its one-cycle write strobe
//   lru_victim_i         least-recently-used way read back from LRU_Unit
//   evict_req_o/way_o    level writeback request and the victim way
//   evict_done_i         writeback complete pulse
//   refill_req_o         level refill request into evict_way_o
//   refill_done_i        refill complete pulse
//   resp_valid_o/way_o   one-cycle completion pulse and the way holding the line
//   err_o                sticky timeout flag, cleared by the next accepted request
// ---------------------------------------------------------------------------
module lru_repl_sequencer #(
    parameter int NUM_WAYS_SQRT = 2,
    parameter int INDEX_WIDTH   = 12,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [INDEX_WIDTH-1:0]   req_index_i,
    input  logic                     req_hit_i,
    input  logic [NUM_WAYS_SQRT-1:0] req_way_i,
    input  logic                     victim_dirty_i,
    output logic [INDEX_WIDTH-1:0]   lru_addr_o,
    output logic [NUM_WAYS_SQRT-1:0] lru_way_o,
    output logic                     lru_we_o,
    input  logic [NUM_WAYS_SQRT-1:0] lru_victim_i,
    output logic                     evict_req_o,
    output logic [NUM_WAYS_SQRT-1:0] evict_way_o,
    input  logic                     evict_done_i,
    output logic                     refill_req_o,
    input  logic                     refill_done_i,
    output logic                     resp_valid_o,
    output logic [NUM_WAYS_SQRT-1:0] resp_way_o,
    output logic                     err_o
);

    typedef enum logic [2:0] {
        IDLE,
        LRU_RD,
        DECIDE,
        EVICT,
        REFILL,
        LRU_UPD,
        RESP
    } state_t;

    // The wait counter starts at zero in the first EVICT/REFILL cycle, so the
    // last permitted cycle is the one where it reads TIMEOUT-1.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [INDEX_WIDTH-1:0]   index_q;
    logic                     hit_q;
    logic [NUM_WAYS_SQRT-1:0] way_q;
    logic [NUM_WAYS_SQRT-1:0] victim_q;
    logic [7:0]               cnt_q;
    logic                     err_q;

    logic                     accept;
    logic                     cnt_clear;
    logic                     timeout;
    logic [NUM_WAYS_SQRT-1:0] upd_way;

    // Way that ends up most-recent: the hit way, or the latched victim on a miss.
    assign upd_way = hit_q ? way_q : victim_q;

    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        cnt_clear    = 1'b0;
        timeout      = 1'b0;
        req_ready_o  = 1'b0;
        lru_we_o     = 1'b0;
        evict_req_o  = 1'b0;
        refill_req_o = 1'b0;
        resp_valid_o = 1'b0;
        resp_way_o   = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = LRU_RD;
                end
            end
            LRU_RD: begin
                state_d = hit_q ? LRU_UPD : DECIDE;
            end
            DECIDE: begin
                cnt_clear = 1'b1;
                state_d   = victim_dirty_i ? EVICT : REFILL;
            end
            EVICT: begin
                // evict_done_i wins over a simultaneous refill_done_i, which
                // is simply not looked at in this state.
                evict_req_o = 1'b1;
                if (evict_done_i) begin
                    cnt_clear = 1'b1;
                    state_d   = REFILL;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = LRU_UPD;
                end
            end
            REFILL: begin
                refill_req_o = 1'b1;
                if (refill_done_i) begin
                    state_d = LRU_UPD;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    state_d = LRU_UPD;
                end
            end
            LRU_UPD: begin
                lru_we_o = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_way_o   = upd_way;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            index_q  <= '0;
            hit_q    <= 1'b0;
            way_q    <= '0;
            victim_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                index_q <= req_index_i;
                hit_q   <= req_hit_i;
                way_q   <= req_way_i;
            end
            if (state_q == DECIDE) begin
                victim_q <= lru_victim_i;
            end
            if (cnt_clear) begin
                cnt_q <= '0;
            end else if (state_q == EVICT || state_q == REFILL) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (accept) begin
                err_q <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign lru_addr_o  = index_q;
    assign lru_way_o   = upd_way;
    assign evict_way_o = victim_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_lru_repl_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lru_repl_sequencer
//
// Self-checking bench for lru_repl_sequencer. A small true-LRU model stands
// in for LRU_Unit, a responder answers evict/refill requests after a chosen
// delay, and each request pushes its expected LRU write and response into a
// scoreboard queue that a monitor pops as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_lru_repl_sequencer;

    typedef struct packed {
        logic [11:0] idx;
        logic [1:0]  way;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [11:0] req_index_i = '0;
    logic        req_hit_i = 1'b0;
    logic [1:0]  req_way_i = '0;
    logic        victim_dirty_i = 1'b0;
    logic [11:0] lru_addr_o;
    logic [1:0]  lru_way_o;
    logic        lru_we_o;
    logic [1:0]  lru_victim_i;
    logic        evict_req_o;
    logic [1:0]  evict_way_o;
    logic        evict_done_i = 1'b0;
    logic        refill_req_o;
    logic        refill_done_i = 1'b0;
    logic        resp_valid_o;
    logic [1:0]  resp_way_o;
    logic        err_o;

    int   n_checks = 0;
    int   n_fails = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    int   last_gap = 0;
    int   we_lat = 0;
    int   resp_lat = 0;
    int   we_count = 0;
    int   ev_total = 0;
    int   rf_total = 0;
    int   evict_delay = 1;
    int   refill_delay = 1;
    bit   dual_done = 1'b0;
    bit   force_en = 1'b0;
    logic [1:0] force_val = '0;
    logic [1:0] model_victim = '0;
    logic [1:0] rank_map [int];

    exp_t upd_q[$];
    exp_t resp_q[$];

    lru_repl_sequencer #(
        .NUM_WAYS_SQRT(2),
        .INDEX_WIDTH  (12),
        .TIMEOUT      (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_index_i   (req_index_i),
        .req_hit_i     (req_hit_i),
        .req_way_i     (req_way_i),
        .victim_dirty_i(victim_dirty_i),
        .lru_addr_o    (lru_addr_o),
        .lru_way_o     (lru_way_o),
        .lru_we_o      (lru_we_o),
        .lru_victim_i  (lru_victim_i),
        .evict_req_o   (evict_req_o),
        .evict_way_o   (evict_way_o),
        .evict_done_i  (evict_done_i),
        .refill_req_o  (refill_req_o),
        .refill_done_i (refill_done_i),
        .resp_valid_o  (resp_valid_o),
        .resp_way_o    (resp_way_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    assign lru_victim_i = force_en ? force_val : model_victim;

    // Counts one comparison and reports it when the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     tag, actual, expected, $time);
        end
    endtask

    // Recency rank of a way in the LRU model: 0 = least recent, 3 = most.
    // Untouched rows start with rank equal to the way number.
    function automatic logic [1:0] rankOf(input logic [11:0] idx, input int w);
        int key;
        key = {18'd0, idx, w[1:0]};
        if (rank_map.exists(key)) return rank_map[key];
        return w[1:0];
    endfunction

    function automatic logic [1:0] modelLru(input logic [11:0] idx);
        for (int w = 0; w < 4; w++) begin
            if (rankOf(idx, w) == 2'd0) return w[1:0];
        end
        return 2'd0;
    endfunction

    task automatic markMru(input logic [11:0] idx, input logic [1:0] way);
        logic [1:0] r;
        logic [1:0] ranks [4];
        r = rankOf(idx, int'(way));
        for (int v = 0; v < 4; v++) begin
            ranks[v] = rankOf(idx, v);
            if (ranks[v] > r) ranks[v] = ranks[v] - 2'd1;
        end
        ranks[way] = 2'd3;
        for (int v = 0; v < 4; v++) begin
            rank_map[{18'd0, idx, 2'(v)}] = ranks[v];
        end
    endtask

    // LRU_Unit stand-in: registered victim read of the addressed row, plus
    // a most-recent update whenever the write strobe is high.
    initial begin : lru_stub
        forever begin
            @(posedge clk_i);
            model_victim = modelLru(lru_addr_o);
            if (rst_ni && lru_we_o) markMru(lru_addr_o, lru_way_o);
        end
    end

    // Memory-side responder: answers a held request after a set number of
    // cycles; a delay of 0 means the done pulse never comes.
    initial begin : responder
        int ev_cnt;
        int rf_cnt;
        ev_cnt = 0;
        rf_cnt = 0;
        forever begin
            @(negedge clk_i);
            evict_done_i  = 1'b0;
            refill_done_i = 1'b0;
            if (evict_req_o) begin
                ev_cnt++;
                ev_total++;
                if (ev_cnt == evict_delay) begin
                    evict_done_i = 1'b1;
                    if (dual_done) refill_done_i = 1'b1;
                end
            end else begin
                ev_cnt = 0;
            end
            if (refill_req_o) begin
                rf_cnt++;
                rf_total++;
                if (rf_cnt == refill_delay) refill_done_i = 1'b1;
            end else begin
                rf_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: every LRU write and every response must match the
    // oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_ni && lru_we_o) begin
                if (upd_q.size() == 0) begin
                    checkOutput("unexpected_lru_we", 32'd1, 32'd0);
                end else begin
                    e = upd_q.pop_front();
                    checkOutput("lru_addr", 32'(lru_addr_o), 32'(e.idx));
                    checkOutput("lru_way", 32'(lru_way_o), 32'(e.way));
                    we_lat = cyc - accept_cyc + 1;
                    we_count++;
                end
            end
            if (rst_ni && resp_valid_o) begin
                if (resp_q.size() == 0) begin
                    checkOutput("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = resp_q.pop_front();
                    checkOutput("resp_way", 32'(resp_way_o), 32'(e.way));
                    checkOutput("resp_err", 32'(err_o), 32'(e.err));
                    resp_lat = cyc - accept_cyc + 1;
                end
            end
        end
    end

    // Waits for the sequencer to be ready, issues one request and records
    // what the scoreboard should see for it.
    task automatic applyStimulus(input logic [11:0] idx, input logic hit,
                                 input logic [1:0] way, input logic dirty,
                                 input bit fen, input logic [1:0] fval,
                                 input logic [1:0] exp_way, input logic exp_err);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk_i);
        while (!req_ready_o && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (!req_ready_o) begin
            checkOutput("ready_wait", 32'(req_ready_o), 32'd1);
            return;
        end
        force_en       = fen;
        force_val      = fval;
        victim_dirty_i = dirty;
        req_index_i    = idx;
        req_hit_i      = hit;
        req_way_i      = way;
        req_valid_i    = 1'b1;
        e.idx = idx;
        e.way = exp_way;
        e.err = exp_err;
        upd_q.push_back(e);
        resp_q.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        last_gap    = cyc - accept_cyc;
        accept_cyc  = cyc;
    endtask

    task automatic waitResp(input string tag);
        int n;
        n = 0;
        while (resp_q.size() != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput(tag, 32'(resp_q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        int ev_base;
        int rf_base;
        int we_base;
        int n;
        logic [11:0] ridx;
        logic        rhit;
        logic [1:0]  rway;
        logic [1:0]  rexp;

        // Reset values
        #2;
        checkOutput("rst_ready", 32'(req_ready_o), 32'd1);
        checkOutput("rst_outs", {27'd0, lru_we_o, evict_req_o, refill_req_o,
                                 resp_valid_o, err_o}, 32'd0);
        checkOutput("rst_ways", {26'd0, lru_way_o, evict_way_o, resp_way_o}, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Hit: write at cycle 2, response at cycle 3, no memory traffic
        rf_base = rf_total;
        ev_base = ev_total;
        applyStimulus(12'h0A5, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
        waitResp("hit_done");
        checkOutput("hit_we_latency", 32'(we_lat), 32'd2);
        checkOutput("hit_resp_latency", 32'(resp_lat), 32'd3);
        checkOutput("hit_no_memory", 32'((rf_total - rf_base) + (ev_total - ev_base)), 32'd0);

        // Clean miss, victim 1, refill answered on its third cycle
        refill_delay = 3;
        rf_base = rf_total;
        ev_base = ev_total;
        applyStimulus(12'h3FF, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0);
        waitResp("clean_done");
        checkOutput("clean_refill_cycles", 32'(rf_total - rf_base), 32'd3);
        checkOutput("clean_no_evict", 32'(ev_total - ev_base), 32'd0);

        // Dirty miss, victim 3, evict done in the first EVICT cycle together
        // with a stray refill done that must not end the refill early
        evict_delay  = 1;
        refill_delay = 2;
        dual_done    = 1'b1;
        rf_base = rf_total;
        ev_base = ev_total;
        applyStimulus(12'h155, 1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 2'd3, 1'b0);
        while (!evict_req_o && resp_q.size() != 0) @(negedge clk_i);
        checkOutput("dirty_evict_way", 32'(evict_way_o), 32'd3);
        waitResp("dirty_done");
        dual_done = 1'b0;
        checkOutput("dirty_evict_cycles", 32'(ev_total - ev_base), 32'd1);
        checkOutput("dirty_refill_cycles", 32'(rf_total - rf_base), 32'd2);

        // Refill never completes: four REFILL cycles, then error and update
        refill_delay = 0;
        rf_base = rf_total;
        applyStimulus(12'h2AA, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, 2'd2, 1'b1);
        waitResp("timeout_done");
        checkOutput("timeout_refill_cycles", 32'(rf_total - rf_base), 32'd4);
        @(negedge clk_i);
        checkOutput("err_sticky", 32'(err_o), 32'd1);
        refill_delay = 1;

        // Back-to-back hits on ways 0..3, then a miss that must pick way 0
        for (int w = 0; w < 4; w++) begin
            applyStimulus(12'h123, 1'b1, 2'(w), 1'b0, 1'b0, 2'd0, 2'(w), 1'b0);
            if (w == 0) checkOutput("err_cleared", 32'(err_o), 32'd0);
            else checkOutput("b2b_gap", 32'(last_gap), 32'd4);
        end
        applyStimulus(12'h123, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0);
        waitResp("b2b_done");
        applyStimulus(12'h123, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0);
        applyStimulus(12'h123, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        waitResp("b2b_miss2_done");

        // Mixed traffic with victims predicted by the LRU model
        for (int i = 0; i < 16; i++) begin
            ridx = 12'h010 + 12'($urandom_range(0, 2));
            rhit = 1'($urandom_range(0, 1));
            rway = 2'($urandom_range(0, 3));
            evict_delay  = $urandom_range(1, 3);
            refill_delay = $urandom_range(1, 3);
            rexp = rhit ? rway : modelLru(ridx);
            applyStimulus(ridx, rhit, rway, 1'($urandom_range(0, 1)), 1'b0, 2'd0,
                          rexp, 1'b0);
            waitResp("mixed_done");
        end

        // Reset in the middle of an eviction
        evict_delay = 0;
        applyStimulus(12'h0F0, 1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 2'd2, 1'b0);
        n = 0;
        while (!evict_req_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("reach_evict", 32'(evict_req_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        upd_q.delete();
        resp_q.delete();
        we_base = we_count;
        checkOutput("rst_mid_evict_req", 32'(evict_req_o), 32'd0);
        checkOutput("rst_mid_ready", 32'(req_ready_o), 32'd1);
        checkOutput("rst_mid_we", 32'(lru_we_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (8) @(negedge clk_i);
        checkOutput("rst_no_we_after", 32'(we_count - we_base), 32'd0);
        checkOutput("rst_idle_ready", 32'(req_ready_o), 32'd1);

        // Recovery after reset
        evict_delay = 1;
        applyStimulus(12'h0A5, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 2'd1, 1'b0);
        waitResp("recover_done");

        repeat (3) @(negedge clk_i);
        checkOutput("upd_queue_empty", 32'(upd_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
